prng_arbiter: RTL
=================

// Module: prng_arbiter
// PURPOSE
//  Shares one xorshift32 pseudo-random generator among NUM_REQ requesters, e.g. move-order
//  tie-break and Zobrist table initialisation. Uses round-robin, with at most one draw per cycle.
//  Every accepted draw returns a distinct successive state of the sequence.
//  Owns reseeding and a post-seed warm-up discard phase, sequenced by a small FSM.
// PARAMETERS
//  NUM_REQ       4         number of requesters (2..16)
//  WARMUP_STEPS  8         generator steps discarded after reset/reseed (0 = none; max 255)
//  RESET_SEED    32'hABCD  generator state loaded by reset
// PORTS
//  clk          in   1        clock
//  reset        in   1        synchronous, active-high
//  seed_valid   in   1        load seed (1-cycle pulse; ignored while not in RUN)
//  seed         in   32       new generator state; 0 is replaced by 1
//  req          in   NUM_REQ  per-requester draw request (valid), level
//  gnt          out  NUM_REQ  one-hot grant (ready), combinational from req, ptr and FSM state
//  rnd          out  32       current generator state; the draw value when req[i]&gnt[i]
//  busy         out  1        high in WARMUP (no grants possible)
//  draw_count   out  32       total accepted draws since reset, wraps at 2^32
// BEHAVIOUR
//  Step function f(x), 32-bit, all shifts truncating:
//  - z = (x==0) ? 1 : x
//  - z ^= z<<13; z ^= z>>17; z ^= z<<5
//  - f(x) = z
//  FSM states and transitions:
//  - WARMUP -> RUN when wcnt reaches WARMUP_STEPS; immediately if WARMUP_STEPS==0.
//  - RUN -> WARMUP on seed_valid, with state<=seed (0->1) and wcnt<=0.
//  - WARMUP: state<=f(state) each cycle, wcnt++; gnt=0; seed_valid ignored.
//  Reset values: state=RESET_SEED, wcnt=0, ptr=0, draw_count=0, gnt=0.
//  - FSM=WARMUP, or RUN if WARMUP_STEPS==0.
//  - rnd=RESET_SEED, busy=(WARMUP_STEPS!=0).
//  Arbitration:
//  - In RUN with seed_valid=0: gnt = first set bit of req, searching ptr, ptr+1, ... mod NUM_REQ.
//  - Transaction occurs when req[i]&gnt[i]; the requester samples rnd in that same cycle.
//  - On a transaction: state<=f(state), ptr<=(i+1) mod NUM_REQ, draw_count++.
//  - No transaction: state, ptr and draw_count hold; no free-running advance in RUN.
//  - req is level. A requester holding req for k cycles alone gets k successive values.
//  Simultaneous events:
//  - seed_valid with req in RUN: seed wins, gnt=0 that cycle, no draw, ptr holds.
//  - reset overrides everything, including mid-warm-up and mid-draw; no draw is counted.
//  Fairness: any continuously asserted req is granted within NUM_REQ cycles of RUN.
//  Latency: 0 cycles request-to-data (combinational gnt, registered rnd); 1 draw/cycle max.
//  The rnd value is never returned twice without an intervening reseed (period 2^32-1).
// TESTING
//  1 WARMUP_STEPS=0, reset, req=0001 for 2 cycles -> rnd 32'h0000ABCD then 32'hBA592F51;
//    draw_count=2.
//  2 WARMUP_STEPS=8 -> busy and gnt=0 for exactly 8 cycles after reset.
//    First draw equals f^8(32'hABCD), checked against a reference model.
//  3 All req=1111 held 8 cycles -> gnt order 0,1,2,3,0,1,2,3; 8 distinct successive values.
//  4 In RUN, seed_valid=1, seed=0 together with req=0010 -> gnt=0 that cycle.
//    After warm-up, the first draw equals f^WARMUP_STEPS(1), e.g. f(1)=32'h00042021 when
//    WARMUP_STEPS=1.
//  5 reset asserted mid-warm-up and mid-stream -> next cycle state=ABCD, ptr=0,
//    draw_count=0, gnt=0.
//  6 Random req for 10k cycles vs. a model -> values match f-sequence, one-hot gnt,
//    max wait <= NUM_REQ, draw_count wraps correctly when preset via force.

Source files
------------

// File: rtl/prng_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : prng_arbiter
//  Description : One xorshift32 generator shared round-robin among NUM_REQ
//                requesters. Each accepted draw returns the next value of the
//                sequence. Handles reseeding and a warm-up phase that discards
//                a fixed number of steps after each seed load.
//  Revision    : 1.0  initial release
// ============================================================================
module prng_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter int          WARMUP_STEPS = 8,
  parameter logic [31:0] RESET_SEED   = 32'hABCD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seed_valid,
  input  logic [31:0]        seed,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [31:0]        rnd,
  output logic               busy,
  output logic [31:0]        draw_count
);

  localparam int         PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam bit         HAS_WARMUP = (WARMUP_STEPS != 0);
  localparam logic [8:0] WARMUP_N   = 9'(WARMUP_STEPS);

  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } fsm_t;

  localparam fsm_t RESET_FSM = HAS_WARMUP ? ST_WARMUP : ST_RUN;

  // xorshift32 step; a zero state is treated as 1 so the sequence never locks up
  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] z;
    z = (x == 32'd0) ? 32'd1 : x;
    z = z ^ (z << 13);
    z = z ^ (z >> 17);
    z = z ^ (z << 5);
    return z;
  endfunction

  fsm_t              fsm;
  fsm_t              fsm_next;
  logic [31:0]       gen_state;
  logic [7:0]        wcnt;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic [31:0]       draw_cnt;
  logic              eligible;
  logic              take;
  logic [PTR_W-1:0]  grant_idx;
  logic              up_hit;
  logic [PTR_W-1:0]  up_idx;
  logic              any_hit;
  logic [PTR_W-1:0]  any_idx;
  logic              warmup_done;

  assign rnd        = gen_state;
  assign busy       = (fsm == ST_WARMUP);
  assign draw_count = draw_cnt;

  // last warm-up step is being taken this cycle
  assign warmup_done = !HAS_WARMUP || (({1'b0, wcnt} + 9'd1) == WARMUP_N);

  // grants only in RUN, and a reseed or reset in the same cycle suppresses them
  assign eligible = !reset && (fsm == ST_RUN) && !seed_valid;

  // round-robin search: lowest set request at or above ptr, else lowest overall
  always_comb begin
    up_hit    = 1'b0;
    up_idx    = '0;
    any_hit   = 1'b0;
    any_idx   = '0;
    gnt       = '0;
    take      = 1'b0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_hit = 1'b1;
        any_idx = PTR_W'(i);
        if (i >= int'(ptr)) begin
          up_hit = 1'b1;
          up_idx = PTR_W'(i);
        end
      end
    end
    if (eligible && any_hit) begin
      take           = 1'b1;
      grant_idx      = up_hit ? up_idx : any_idx;
      gnt[grant_idx] = 1'b1;
    end
  end

  // pointer moves to the requester just after the one served
  always_comb begin
    ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
  end

  // next-state logic for the warm-up / run sequencer
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      ST_WARMUP: if (warmup_done) fsm_next = ST_RUN;
      ST_RUN:    if (seed_valid && HAS_WARMUP) fsm_next = ST_WARMUP;
      default:   fsm_next = RESET_FSM;
    endcase
  end

  // sequencer state register
  always_ff @(posedge clk) begin
    if (reset) fsm <= RESET_FSM;
    else       fsm <= fsm_next;
  end

  // generator state, warm-up counter, arbitration pointer and draw counter
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_state <= RESET_SEED;
      wcnt      <= '0;
      ptr       <= '0;
      draw_cnt  <= '0;
    end else begin
      draw_cnt <= draw_cnt + {31'd0, take};
      case (fsm)
        ST_WARMUP: begin
          gen_state <= xorshift32(gen_state);
          wcnt      <= wcnt + 8'd1;
        end
        ST_RUN: begin
          if (seed_valid) begin
            gen_state <= (seed == 32'd0) ? 32'd1 : seed;
            wcnt      <= '0;
          end else if (take) begin
            gen_state <= xorshift32(gen_state);
            ptr       <= ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
